// File: rtl/delta_arbiter_pkg.sv
// Shared definitions for the per-channel delta scheduler.
// Config addresses and the decoded config operation type.
package delta_arbiter_pkg;

    localparam logic [15:0] ARB_EN_ADDR   = 16'h0040;
    localparam logic [15:0] ARB_CLR_ADDR  = 16'h0041;
    localparam logic [15:0] ARB_IDLE_ADDR = 16'h0042;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_EN,
        OP_CLR,
        OP_IDLE
    } cfg_op_e;

    function automatic cfg_op_e decode_op(input logic en,
                                          input logic [15:0] addr);
        decode_op = OP_NONE;
        if (en) begin
            case (addr)
                ARB_EN_ADDR:   decode_op = OP_EN;
                ARB_CLR_ADDR:  decode_op = OP_CLR;
                ARB_IDLE_ADDR: decode_op = OP_IDLE;
                default:       decode_op = OP_NONE;
            endcase
        end
    endfunction

endpackage

// File: rtl/delta_arbiter_rr.sv
// Round-robin priority search with its own pointer register.
// The pointer only moves when a grant is actually issued.
module rr_arbiter #(
    parameter int N     = 8,
    parameter int W_IDX = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             adv,
    output logic             gnt_valid,
    output logic [W_IDX-1:0] gnt_idx
);

    localparam int W_SEL = (N > 1) ? $clog2(N) : 1;

    logic [W_IDX-1:0] ptr;
    logic [W_IDX-1:0] ptr_nxt;
    logic [W_SEL-1:0] sel;
    int               s;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        sel       = '0;
        s         = 0;
        for (int i = 0; i < N; i++) begin
            s = int'(ptr) + i;
            if (s >= N) s = s - N;
            sel = W_SEL'(s);
            if (adv && !gnt_valid && req[sel]) begin
                gnt_valid = 1'b1;
                gnt_idx   = W_IDX'(s);
            end
        end
        ptr_nxt = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + W_IDX'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (gnt_valid) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/delta_arbiter.sv
// Buffers one coalesced delta per channel and issues them round-robin
// to output_filter, with programmable forced-idle insertion.
module delta_arbiter
    import delta_arbiter_pkg::*;
#(
    parameter int W_CHAN    = 5,
    parameter int N_CHAN    = 8,
    parameter int W_DELTA   = 18,
    parameter int W_IDLE    = 8,
    parameter int W_CCNT    = 16,
    parameter int W_WR_ADDR = 16,
    parameter int W_WR_CHAN = 5,
    parameter int W_WR_DATA = 48
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [N_CHAN-1:0]           req_dv_in,
    input  logic [N_CHAN*W_DELTA-1:0]   req_delta_in,
    input  logic                        wr_en,
    input  logic [W_WR_ADDR-1:0]        wr_addr,
    input  logic [W_WR_CHAN-1:0]        wr_chan,
    input  logic [W_WR_DATA-1:0]        wr_data,
    output logic                        dv_out,
    output logic [W_CHAN-1:0]           chan_out,
    output logic signed [W_DELTA-1:0]   delta_out,
    output logic [N_CHAN-1:0]           pend_out,
    output logic [W_CCNT-1:0]           ccnt_out
);

    localparam logic [W_DELTA-1:0] DMAX = {1'b0, {(W_DELTA-1){1'b1}}};
    localparam logic [W_DELTA-1:0] DMIN = {1'b1, {(W_DELTA-1){1'b0}}};

    logic [W_DELTA-1:0] dbuf  [N_CHAN];
    logic [W_DELTA-1:0] buf_d [N_CHAN];
    logic [N_CHAN-1:0]  pend_q, pend_d, en_q, clr, gnt_oh, coal;
    logic [W_IDLE-1:0]  idle_p, idle_cnt;
    logic [W_DELTA-1:0] gnt_delta;
    logic [W_CCNT:0]    csum;
    logic [W_CHAN-1:0]  gnt_idx;
    logic               gnt_valid, force_idle, wr_ok, stb;
    cfg_op_e            op;
    logic               wr_data_unused;

    function automatic logic [W_DELTA-1:0] sat_add(
        input logic [W_DELTA-1:0] a,
        input logic [W_DELTA-1:0] b
    );
        logic [W_DELTA:0] s;
        s = {a[W_DELTA-1], a} + {b[W_DELTA-1], b};
        if (s[W_DELTA] != s[W_DELTA-1]) sat_add = s[W_DELTA] ? DMIN : DMAX;
        else                            sat_add = s[W_DELTA-1:0];
    endfunction

    assign wr_data_unused = ^wr_data[W_WR_DATA-1:W_IDLE];
    assign op             = decode_op(wr_en, 16'(wr_addr));
    assign wr_ok          = int'(wr_chan) < N_CHAN;
    assign force_idle     = (idle_p != '0) && (idle_cnt >= idle_p);
    assign pend_out       = pend_q;

    rr_arbiter #(.N(N_CHAN), .W_IDX(W_CHAN)) u_rr (
        .clk       (clk_in),
        .rst       (rst_in),
        .req       (pend_q & en_q),
        .adv       (~force_idle),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        pend_d    = pend_q;
        buf_d     = dbuf;
        coal      = '0;
        clr       = '0;
        gnt_oh    = '0;
        gnt_delta = '0;
        stb       = 1'b0;
        for (int i = 0; i < N_CHAN; i++) begin
            clr[i] = wr_ok && (int'(wr_chan) == i) &&
                     (op == OP_CLR || (op == OP_EN && !wr_data[0]));
            gnt_oh[i] = gnt_valid && (int'(gnt_idx) == i);
            if (gnt_oh[i]) gnt_delta = dbuf[i];
            stb = req_dv_in[i] && en_q[i];
            // A clear beats a same-cycle strobe, but never a grant.
            if (clr[i]) begin
                pend_d[i] = 1'b0;
            end else if (stb) begin
                pend_d[i] = 1'b1;
                if (pend_q[i] && !gnt_oh[i]) begin
                    buf_d[i] = sat_add(dbuf[i], req_delta_in[i*W_DELTA +: W_DELTA]);
                    coal[i]  = 1'b1;
                end else begin
                    buf_d[i] = req_delta_in[i*W_DELTA +: W_DELTA];
                end
            end else if (gnt_oh[i]) begin
                pend_d[i] = 1'b0;
            end
        end
        csum = {1'b0, ccnt_out} + (W_CCNT+1)'($countones(coal));
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pend_q    <= '0;
            en_q      <= '1;
            idle_p    <= '0;
            idle_cnt  <= '0;
            dv_out    <= 1'b0;
            chan_out  <= '0;
            delta_out <= '0;
            ccnt_out  <= '0;
            for (int i = 0; i < N_CHAN; i++) dbuf[i] <= '0;
        end else begin
            pend_q <= pend_d;
            dbuf   <= buf_d;
            if (op == OP_IDLE) idle_p <= wr_data[W_IDLE-1:0];
            for (int i = 0; i < N_CHAN; i++) begin
                if (op == OP_EN && wr_ok && int'(wr_chan) == i) en_q[i] <= wr_data[0];
            end
            ccnt_out <= csum[W_CCNT] ? '1 : csum[W_CCNT-1:0];
            if (!gnt_valid)          idle_cnt <= '0;
            else if (idle_cnt != '1) idle_cnt <= idle_cnt + W_IDLE'(1);
            dv_out <= gnt_valid;
            if (gnt_valid) begin
                chan_out  <= gnt_idx;
                delta_out <= gnt_delta;
            end
        end
    end

endmodule
